// File: rtl/division_repeated_sub_if.sv
// Request/result bundle for the repeated-subtraction divider.
// Request side: a transfer happens on an edge where valid_in && ready_out; result side: on valid_out && ready_in.
interface division_repeated_sub_if #(
  parameter int DW = 8,
  parameter int SW = 4
);
  logic [DW-1:0] in_dividend;
  logic [SW-1:0] in_divisor;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic          valid_out;
  logic          ready_in;

  modport slave (
    input  in_dividend, in_divisor, valid_in, ready_in,
    output ready_out, quotient, remainder, div_by_zero, valid_out
  );

  modport master (
    output in_dividend, in_divisor, valid_in, ready_in,
    input  ready_out, quotient, remainder, div_by_zero, valid_out
  );
endinterface

// File: rtl/division_repeated_sub.sv
// Unsigned divider: subtracts the divisor from the running remainder once per cycle,
// counting subtractions, then presents the result under valid_out/ready_in backpressure.
module division_repeated_sub #(
  parameter int DW = 8,
  parameter int SW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  division_repeated_sub_if.slave  bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] rem_reg;
  logic [DW-1:0] quo_reg;
  logic [SW-1:0] div_reg;
  logic [DW-1:0] div_ext;
  logic          div_zero;
  logic          can_sub;

  assign div_ext  = DW'(div_reg);
  assign div_zero = (div_reg == '0);
  assign can_sub  = (rem_reg >= div_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.valid_in) state_nx = CALC;
      CALC:    if (div_zero || !can_sub) state_nx = DONE;
      DONE:    if (bus.ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags come straight off the state register, so they only move on edges.
  always_comb begin
    bus.ready_out = (state == IDLE);
    bus.valid_out = (state == DONE);
    dbg_state     = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg         <= '0;
      quo_reg         <= '0;
      div_reg         <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            rem_reg <= bus.in_dividend;
            div_reg <= bus.in_divisor;
            quo_reg <= '0;
          end
        end
        CALC: begin
          if (div_zero) begin
            bus.quotient    <= '1;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b1;
          end else if (can_sub) begin
            rem_reg <= rem_reg - div_ext;
            quo_reg <= quo_reg + DW'(1);
          end else begin
            // rem_reg < divisor here, so the low SW bits hold the whole remainder.
            bus.quotient    <= quo_reg;
            bus.remainder   <= rem_reg[SW-1:0];
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division_repeated_sub.sv
// Directed and randomized checks of the repeated-subtraction divider.
module tb_division_repeated_sub;
  localparam int DW = 8;
  localparam int SW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  logic [DW+SW:0]   exp_q[$];
  logic [DW+SW-1:0] opd_q[$];

  division_repeated_sub_if #(.DW(DW), .SW(SW)) bus ();

  division_repeated_sub #(.DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Producer must hold a pending request stable until it is accepted.
  logic          pend = 1'b0;
  logic [DW-1:0] pend_a = '0;
  logic [SW-1:0] pend_b = '0;
  always @(posedge clk) begin
    if (rst_n && pend)
      assert (bus.valid_in && bus.in_dividend == pend_a && bus.in_divisor == pend_b)
        else $error("FAIL input_protocol request changed while pending");
    pend   <= rst_n && bus.valid_in && !bus.ready_out;
    pend_a <= bus.in_dividend;
    pend_b <= bus.in_divisor;
  end

  always @(negedge clk)
    if (rst_n)
      assert (!(bus.valid_out && bus.ready_out))
        else $error("FAIL valid_ready_overlap both high");

  task automatic start_req(input logic [DW-1:0] a, input logic [SW-1:0] b);
    @(negedge clk);
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.valid_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_result(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.valid_out) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({bus.ready_out, bus.valid_out, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%0d r=%0d dbz=%b want rdy=1 vld=0 q=0 r=0 dbz=0",
               bus.ready_out, bus.valid_out, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.ready_out, bus.valid_out} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset_idle got rdy=%b vld=%b want rdy=1 vld=0", bus.ready_out, bus.valid_out);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    logic [DW-1:0] a_tab[3] = '{8'd100, 8'd5, 8'd0};
    logic [SW-1:0] b_tab[3] = '{4'd7, 4'd9, 4'd3};
    logic [DW-1:0] q_tab[3] = '{8'd14, 8'd0, 8'd0};
    logic [SW-1:0] r_tab[3] = '{4'd2, 4'd5, 4'd0};
    int            l_tab[3] = '{15, 1, 1};
    for (int i = 0; i < 3; i++) begin
      start_req(a_tab[i], b_tab[i]);
      wait_result(cyc, to);
      n_vec++;
      if (to || cyc != l_tab[i]) begin
        n_err++;
        $display("FAIL latency_%0d_%0d got %0d (timeout=%b) want %0d", a_tab[i], b_tab[i], cyc, to, l_tab[i]);
      end
      n_vec++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ready_out} !== {q_tab[i], r_tab[i], 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL result_%0d_%0d got q=%0d r=%0d dbz=%b rdy=%b want q=%0d r=%0d dbz=0 rdy=0",
                 a_tab[i], b_tab[i], bus.quotient, bus.remainder, bus.div_by_zero, bus.ready_out, q_tab[i], r_tab[i]);
      end
      release_result();
      n_vec++;
      if ({bus.ready_out, bus.valid_out} !== 2'b10) begin
        n_err++;
        $display("FAIL handoff_%0d_%0d got rdy=%b vld=%b want rdy=1 vld=0", a_tab[i], b_tab[i], bus.ready_out, bus.valid_out);
      end
    end
  endtask

  task automatic test_extremes();
    int cyc;
    bit to;
    start_req(8'd255, 4'd1);
    wait_result(cyc, to);
    n_vec++;
    if (to || cyc != 256) begin
      n_err++;
      $display("FAIL latency_255_1 got %0d (timeout=%b) want 256", cyc, to);
    end
    n_vec++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd255, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL result_255_1 got q=%0d r=%0d dbz=%b want q=255 r=0 dbz=0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    release_result();
    start_req(8'd200, 4'd0);
    wait_result(cyc, to);
    n_vec++;
    if (to || cyc != 1) begin
      n_err++;
      $display("FAIL latency_200_0 got %0d (timeout=%b) want 1", cyc, to);
    end
    n_vec++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'hFF, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL result_200_0 got q=%h r=%0d dbz=%b want q=ff r=0 dbz=1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit to;
    start_req(8'd77, 4'd6);
    wait_result(cyc, to);
    n_vec++;
    if (to || cyc != 13) begin
      n_err++;
      $display("FAIL latency_77_6 got %0d (timeout=%b) want 13", cyc, to);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.in_dividend = 8'd10;
        bus.in_divisor  = 4'd2;
        bus.valid_in    = 1'b1;
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.valid_out, bus.ready_out, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 8'd12, 4'd5, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold_%0d got vld=%b rdy=%b q=%0d r=%0d dbz=%b want vld=1 rdy=0 q=12 r=5 dbz=0",
                 i, bus.valid_out, bus.ready_out, bus.quotient, bus.remainder, bus.div_by_zero);
      end
    end
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    n_vec++;
    if ({bus.ready_out, bus.valid_out, bus.quotient, bus.remainder} !== {1'b1, 1'b0, 8'd12, 4'd5}) begin
      n_err++;
      $display("FAIL stall_release got rdy=%b vld=%b q=%0d r=%0d want rdy=1 vld=0 q=12 r=5",
               bus.ready_out, bus.valid_out, bus.quotient, bus.remainder);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.ready_out !== 1'b0) begin
      n_err++;
      $display("FAIL accept_after_handoff got rdy=%b want 0", bus.ready_out);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    wait_result(cyc, to);
    n_vec++;
    if (to || cyc != 6 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd5, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL result_10_2 got lat=%0d q=%0d r=%0d dbz=%b want lat=6 q=5 r=0 dbz=0",
               cyc, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    release_result();
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    bit to;
    start_req(8'd200, 4'd3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.valid_out, bus.ready_out, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b0, 1'b1, 8'd0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_calc_reset got vld=%b rdy=%b q=%0d r=%0d dbz=%b want vld=0 rdy=1 q=0 r=0 dbz=0",
               bus.valid_out, bus.ready_out, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_req(8'd9, 4'd4);
    wait_result(cyc, to);
    n_vec++;
    if (to || cyc != 3 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd2, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL result_9_4 got lat=%0d q=%0d r=%0d dbz=%b want lat=3 q=2 r=1 dbz=0",
               cyc, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    release_result();
  endtask

  task automatic test_random_sweep();
    int cyc;
    bit to;
    logic [DW-1:0]  a;
    logic [SW-1:0]  b;
    logic [DW+SW:0] exp;
    logic [DW+SW-1:0] opd;
    logic [DW+SW:0] got;
    for (int n = 0; n < 200; n++) begin
      a = DW'($urandom_range(0, 255));
      b = SW'($urandom_range(0, 15));
      if (b == 0) exp = {1'b1, 8'hFF, 4'd0};
      else        exp = {1'b0, DW'(a / b), SW'(a % b)};
      exp_q.push_back(exp);
      opd_q.push_back({a, b});
      start_req(a, b);
      wait_result(cyc, to);
      exp = exp_q.pop_front();
      opd = opd_q.pop_front();
      got = {bus.div_by_zero, bus.quotient, bus.remainder};
      n_vec++;
      if (to || got !== exp) begin
        n_err++;
        $display("FAIL sweep_%0d_%0d got dbz=%b q=%0d r=%0d (timeout=%b) want dbz=%b q=%0d r=%0d",
                 opd[DW+SW-1:SW], opd[SW-1:0], got[DW+SW], got[DW+SW-1:SW], got[SW-1:0], to,
                 exp[DW+SW], exp[DW+SW-1:SW], exp[SW-1:0]);
      end
      if (!bus.div_by_zero && opd[SW-1:0] != 0) begin
        n_vec++;
        if ((int'(bus.quotient) * int'(opd[SW-1:0]) + int'(bus.remainder)) != int'(opd[DW+SW-1:SW]) ||
            bus.remainder >= opd[SW-1:0]) begin
          n_err++;
          $display("FAIL sweep_invariant a=%0d b=%0d got q=%0d r=%0d", opd[DW+SW-1:SW], opd[SW-1:0], bus.quotient, bus.remainder);
        end
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.valid_out, bus.ready_out, bus.div_by_zero, bus.quotient, bus.remainder} !== {1'b1, 1'b0, got}) begin
          n_err++;
          $display("FAIL sweep_stall got vld=%b rdy=%b dbz=%b q=%0d r=%0d want vld=1 rdy=0 held result",
                   bus.valid_out, bus.ready_out, bus.div_by_zero, bus.quotient, bus.remainder);
        end
      end
      release_result();
      n_vec++;
      if ({bus.valid_out, bus.ready_out} !== 2'b01) begin
        n_err++;
        $display("FAIL sweep_handoff got vld=%b rdy=%b want vld=0 rdy=1", bus.valid_out, bus.ready_out);
      end
    end
  endtask

  initial begin
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.valid_in    = 1'b0;
    bus.ready_in    = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_calc();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
